// File: rtl/fconv.sv
// fconv: iterative MIX integer<->float converter (FLOT / FIX), one 6-bit byte per clock.
// Build option: define FCONV_ROUND_EN for round-to-nearest; otherwise results are truncated.
module fconv (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [30:0] in,
  output logic [30:0] out,
  output logic        done,
  output logic        busy,
  output logic        overflow
);

`ifdef FCONV_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  localparam logic [5:0]  FlotExp = 6'd37;
  localparam logic [23:0] FracOne = 24'o01000000;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  typedef enum logic {OP_FLOT = 1'b0, OP_FIX = 1'b1} op_t;

  state_t      state, state_nxt;
  op_t         op_r;
  logic        sign_r;
  logic [29:0] acc_r;     // FLOT: magnitude M; FIX: integer I
  logic [23:0] frac_r;    // FIX: remaining fraction F
  logic [5:0]  exp_r;     // FLOT: running exponent; FIX: input exponent
  logic [4:0]  cnt_r;
  logic        sticky_r;

  // Byte-shift count decided at load time from the operand.
  logic [4:0] k_flot, k_fix, k_load;

  // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    k_flot = 5'd0;
    if (in[29:24] == 6'd0 && in[23:0] != 24'd0) begin
      if (in[23:18] != 6'd0)      k_flot = 5'd1;
      else if (in[17:12] != 6'd0) k_flot = 5'd2;
      else if (in[11:6] != 6'd0)  k_flot = 5'd3;
      else                        k_flot = 5'd4;
    end
    // e > 32 gives e - 32, which is just e[4:0] when e[5] is set.
    k_fix  = in[29] ? in[28:24] : 5'd0;
    k_load = op ? k_fix : k_flot;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_load == 5'd0) ? ROUND : SHIFT;
      SHIFT:   if (cnt_r == 5'd1) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Rounding and result assembly, consumed on the ROUND edge.
  logic [5:0]  rnd_byte;
  logic        rnd_inc;
  logic [24:0] flot_sum;
  logic [30:0] fix_sum;
  logic [30:0] flot_res, fix_res, round_res;
  logic        round_ovf;

  always_comb begin
    rnd_byte = (op_r == OP_FLOT) ? acc_r[5:0] : (exp_r[5] ? frac_r[23:18] : 6'd0);
    rnd_inc  = RoundEn && (rnd_byte >= 6'd32);
    flot_sum = {1'b0, acc_r[29:6]} + {24'd0, rnd_inc};
    fix_sum  = {1'b0, acc_r} + {30'd0, rnd_inc};

    if (acc_r == 30'd0)   flot_res = {sign_r, 30'd0};
    else if (flot_sum[24]) flot_res = {sign_r, exp_r + 6'd1, FracOne};
    else                   flot_res = {sign_r, exp_r, flot_sum[23:0]};

    // An overflowed FIX result deliberately keeps the truncated low 30 bits.
    fix_res   = {sign_r, fix_sum[29:0]};
    round_res = (op_r == OP_FIX) ? fix_res : flot_res;
    round_ovf = (op_r == OP_FIX) && (sticky_r || fix_sum[30]);
  end

  // Datapath.
  // NOTE: all datapath registers are plain flops, so every one is cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r     <= OP_FLOT;
      sign_r   <= 1'b0;
      acc_r    <= 30'd0;
      frac_r   <= 24'd0;
      exp_r    <= 6'd0;
      cnt_r    <= 5'd0;
      sticky_r <= 1'b0;
      out      <= 31'd0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r     <= op_t'(op);
            sign_r   <= in[30];
            cnt_r    <= k_load;
            sticky_r <= 1'b0;
            if (op) begin
              acc_r  <= 30'd0;
              frac_r <= in[23:0];
              exp_r  <= in[29:24];
            end else begin
              acc_r  <= in[29:0];
              frac_r <= 24'd0;
              exp_r  <= FlotExp;
            end
          end
        end
        SHIFT: begin
          cnt_r <= cnt_r - 5'd1;
          if (op_r == OP_FIX) begin
            // A nonzero top byte about to fall off means the integer no longer fits.
            if (acc_r[29:24] != 6'd0) sticky_r <= 1'b1;
            acc_r  <= {acc_r[23:0], frac_r[23:18]};
            frac_r <= {frac_r[17:0], 6'd0};
          end else begin
            acc_r <= {acc_r[23:0], 6'd0};
            exp_r <= exp_r - 6'd1;
          end
        end
        ROUND: begin
          out      <= round_res;
          overflow <= round_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fconv.sv
// Directed self-checking bench for fconv: FLOT/FIX vectors, latency, overflow, ignored starts, reset abort.
module tb_fconv;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [30:0] in;
  logic [30:0] out;
  logic        done;
  logic        busy;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  fconv dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .in       (in),
    .out      (out),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

`ifdef FCONV_ROUND_EN
  localparam logic [30:0] ExpFlotRnd   = {1'b0, 6'o45, 24'o01020305};
  localparam logic [30:0] ExpFlotCarry = {1'b1, 6'o46, 24'o01000000};
  localparam logic [30:0] ExpFixHalf   = 31'd1;
  localparam logic [30:0] ExpFixK1     = 31'd2;
`else
  localparam logic [30:0] ExpFlotRnd   = {1'b0, 6'o45, 24'o01020304};
  localparam logic [30:0] ExpFlotCarry = {1'b1, 6'o45, 24'o77777777};
  localparam logic [30:0] ExpFixHalf   = 31'd0;
  localparam logic [30:0] ExpFixK1     = 31'd1;
`endif

  task automatic check(input string tag, input logic [30:0] obs, input logic [30:0] expd);
    total++;
    assert (obs === expd) passed++;
    else $error("FAIL %s: observed %o expected %o", tag, obs, expd);
  endtask

  // dup: 0 none, 1 extra start while busy, 2 extra start in the DONE cycle
  task automatic run(input string tag, input logic o, input logic [30:0] din, input int exp_lat,
                     input logic [30:0] exp_out, input logic exp_ovf, input int dup);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; in = din;
    @(negedge clk);
    start = 1'b0; in = 31'd0;
    check({tag, " busy_after_start"}, {30'd0, busy}, 31'd1);
    lat = 0;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
      if (dup == 1) begin
        start = (lat == 1);
        op = 1'b0;
        in = {1'b0, 30'o0000000001};
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 31'(lat), 31'(exp_lat));
    check({tag, " out"}, out, exp_out);
    check({tag, " overflow"}, {30'd0, overflow}, {30'd0, exp_ovf});
    check({tag, " busy_at_done"}, {30'd0, busy}, 31'd1);
    if (dup == 2) begin
      start = 1'b1; op = 1'b0; in = {1'b0, 30'o0000000001};
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_cleared"}, {30'd0, done}, 31'd0);
    check({tag, " busy_cleared"}, {30'd0, busy}, 31'd0);
    check({tag, " out_held"}, out, exp_out);
    check({tag, " overflow_held"}, {30'd0, overflow}, {30'd0, exp_ovf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 1'b0;
    in      = 31'd0;
    #12;
    check("reset out", out, 31'd0);
    check("reset done", {30'd0, done}, 31'd0);
    check("reset busy", {30'd0, busy}, 31'd0);
    check("reset overflow", {30'd0, overflow}, 31'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run("flot_one",   1'b0, {1'b0, 30'o0000000001}, 5, {1'b0, 6'o41, 24'o01000000}, 1'b0, 0);
    run("flot_round", 1'b0, {1'b0, 30'o0102030440}, 1, ExpFlotRnd, 1'b0, 2);
    run("flot_carry", 1'b0, {1'b1, 30'o7777777777}, 1, ExpFlotCarry, 1'b0, 0);
    run("flot_zero",  1'b0, {1'b1, 30'o0000000000}, 1, {1'b1, 30'd0}, 1'b0, 0);
    run("fix_ovf",    1'b1, {1'b0, 6'o47, 24'o01000000}, 8, {1'b0, 30'd0}, 1'b1, 0);
    run("fix_k2",     1'b1, {1'b1, 6'o42, 24'o01403000}, 3, {1'b1, 30'o0000000140}, 1'b0, 1);
    run("fix_small",  1'b1, {1'b0, 6'o37, 24'o77777777}, 1, 31'd0, 1'b0, 0);
    run("fix_half",   1'b1, {1'b0, 6'o40, 24'o40000000}, 1, ExpFixHalf, 1'b0, 0);
    run("fix_k1",     1'b1, {1'b0, 6'o41, 24'o01400000}, 2, ExpFixK1, 1'b0, 0);

    // Abort a long FIX with reset asserted across E3.
    @(negedge clk);
    start = 1'b1; op = 1'b1; in = {1'b0, 6'o47, 24'o01000000};
    @(negedge clk);
    start = 1'b0; in = 31'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort out", out, 31'd0);
    check("abort busy", {30'd0, busy}, 31'd0);
    check("abort overflow", {30'd0, overflow}, 31'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= done;
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort no_done", {30'd0, saw_done}, 31'd0);
    check("abort idle", {30'd0, busy}, 31'd0);

    run("after_reset", 1'b0, {1'b0, 30'o0000000001}, 5, {1'b0, 6'o41, 24'o01000000}, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fconv.md
# fconv

Iterative MIX floating-point format converter performing FLOT (signed integer word to normalized float) and FIX (float to rounded signed integer). Companion to the fadd/fmul/fdiv units: those consume and produce MIX floats, and fconv moves values between the integer and float domains. It shifts one 6-bit byte per clock and takes a one-cycle start with a one-cycle done pulse.

## Interface
- No parameters. Byte size 6, float layout {sign, 6-bit exponent excess-32, 4-byte fraction}, word width 31 are fixed.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = FLOT, 1 = FIX; sampled with start.
- in  in  31  operand: FLOT {sign, 30-bit magnitude}; FIX {sign, e[5:0], f[23:0]}.
- out  out  31  result, registered, holds until next done.
- done  out  1  one-cycle pulse; out valid from this cycle.
- busy  out  1  high from the start edge until the done cycle, inclusive.
- overflow  out  1  FIX magnitude exceeded 30 bits; valid with done, held until next done.

## Operation
- States: IDLE, SHIFT, ROUND, DONE.
- Sign is always copied from in[30] to out[30], including zero results.
- FLOT load: M = 5 bytes of magnitude; e = 37; k = count of leading zero bytes (0..4). When M==0, k=0.
- FLOT SHIFT step: M <<= 6, e -= 1.
- FLOT ROUND: fraction = top 4 bytes of M; rounding byte r = byte 5.
  - If r >= 32, fraction += 1.
  - On carry out, fraction = 24'o01000000 and e += 1.
  - M==0 gives out = {sign, 30'b0}.
  - FLOT never overflows.
- FIX load: I = 0 (30 bits); F = f; k = e>32 ? e−32 : 0 (up to 31).
- FIX SHIFT step: if I[29:24] != 0, set the sticky overflow flag. Then I = {I[23:0], F[23:18]}, F = {F[17:0], 6'b0}.
- FIX ROUND: r = (e>=32) ? F[23:18] : 0.
  - If r >= 32, I += 1.
  - A carry beyond bit 29 sets overflow.
  - out = {sign, I[29:0]}, so an overflowed result carries the truncated low bits.
- Unnormalized FIX inputs are legal. Leading zero bytes simply shift through.

## Timing
- Edge E0 samples start=1 in IDLE and loads the operands. busy goes high.
- k=0: E0 goes to ROUND. Otherwise E0 goes to SHIFT.
- SHIFT does one byte per edge, E1..Ek, then goes to ROUND.
- ROUND, at edge E(k+1), writes out and overflow and sets done=1 → DONE.
- DONE, at edge E(k+2), clears done and busy → IDLE.
- Latency start→done = k+1 edges: FLOT 1..5; FIX 1..32.
- start while busy is ignored. start in the DONE cycle is also ignored; the next request is accepted one cycle after done.
- Reset (async, any state) → IDLE. out=0, done=0, busy=0, overflow=0, and internal registers cleared. An in-flight conversion is discarded with no done.

## Configuration
- FCONV_ROUND_EN defined: round-to-nearest as in ROUND above (r >= 32 adds one ulp/unit).
- Undefined: truncation. r is ignored, no increment is made, and no rounding carry or rounding overflow can occur.
- ROUND state and latency are identical in both builds.

## Test plan
- FLOT +1: in={0,30'o0000000001}, op=0 → k=4, done at E5, out={0,6'o41,24'o01000000}.
- FLOT round: in={0,30'o0102030440} → done at E1.
  - With FCONV_ROUND_EN: out={0,6'o45,24'o01020305}.
  - Without: out={0,6'o45,24'o01020304}.
- FLOT round carry, with FCONV_ROUND_EN: in={1,30'o7777777777} → out={1,6'o46,24'o01000000}.
- FIX: in={1,6'o42,24'o01403000}, op=1 → done at E3, out={1,30'o0000000140}, overflow=0.
- FIX small values:
  - {0,6'o37,24'o77777777} → out 0 at E1.
  - {0,6'o40,24'o40000000} → out 1 with rounding, 0 without.
- FIX overflow: in={0,6'o47,24'o01000000} → done at E8, overflow=1, out={0,30'b0}.
- Busy and reset:
  - A second start during the FIX above is ignored.
  - reset_n low at E3 → out=0, busy=0, no done pulse.
  - The next start after reset converts normally.
